// File: rtl/wb_decoder_timeout_if.sv
// Bus bundle around the Wishbone address decoder.
//   m_* : upstream master side (request fields in, response/flow control out)
//   s_* : downstream slave side (shared registered request fields plus
//         per-slave NS-wide strobes and responses)
// Modports, seen from the decoder:
//   slave  : the decoder acts as a Wishbone slave towards the upstream master
//   master : the decoder acts as a Wishbone master towards the NS slaves
interface wb_decoder_timeout_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int TW = 3,
  parameter int NS = 4
) ();
  logic [TW-1:0]    m_tag;
  logic [AW-1:0]    m_adr;
  logic [DW-1:0]    m_dwr;
  logic [DW/8-1:0]  m_sel;
  logic             m_stb;
  logic             m_cyc;
  logic             m_we;
  logic             m_lock;
  logic [DW-1:0]    m_drd;
  logic             m_ack;
  logic             m_err;
  logic             m_stall;

  logic [TW-1:0]    s_tag;
  logic [AW-1:0]    s_adr;
  logic [DW-1:0]    s_dwr;
  logic [DW/8-1:0]  s_sel;
  logic             s_we;
  logic             s_lock;
  logic [NS-1:0]    s_cyc;
  logic [NS-1:0]    s_stb;
  logic [NS*DW-1:0] s_drd;
  logic [NS-1:0]    s_ack;
  logic [NS-1:0]    s_err;
  logic [NS-1:0]    s_stall;

  modport slave (
    input  m_tag, m_adr, m_dwr, m_sel, m_stb, m_cyc, m_we, m_lock,
    output m_drd, m_ack, m_err, m_stall
  );

  modport master (
    output s_tag, s_adr, s_dwr, s_sel, s_we, s_lock, s_cyc, s_stb,
    input  s_drd, s_ack, s_err, s_stall
  );
endinterface

// File: rtl/wb_decoder_timeout.sv
// Wishbone 1-to-NS address decoder with a single outstanding transaction
// and a response timeout.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   host : upstream master port (wb_decoder_timeout_if.slave)
//   dev  : downstream slave ports (wb_decoder_timeout_if.master)
// Slave i is selected when (m_adr & mask_i) == base_i, lowest index first.
// Unmapped addresses and timeouts answer with a one-cycle m_err from RESP.
module wb_decoder_timeout #(
  parameter int                DW       = 32,
  parameter int                AW       = 32,
  parameter int                TW       = 3,
  parameter int                NS       = 4,
  parameter logic [NS*AW-1:0]  SLV_BASE = {(NS*AW){1'b0}},
  parameter logic [NS*AW-1:0]  SLV_MASK = {(NS*AW){1'b0}},
  parameter int                TIMEOUT  = 255
) (
  input logic                   clk,
  input logic                   rst,
  wb_decoder_timeout_if.slave   host,
  wb_decoder_timeout_if.master  dev
);

  localparam int             IW  = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [NS-1:0]  ONE = NS'(1'b1);
  localparam logic [15:0]    TMO = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [15:0]     cnt;
  logic [15:0]     cnt_inc;
  logic            tmo;
  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic            accept;
  logic            in_xfer;
  logic            fwd;
  logic            sel_ack;
  logic            sel_err;
  logic            sel_stall;
  logic [DW-1:0]   sel_drd;

  logic [TW-1:0]   lat_tag;
  logic [AW-1:0]   lat_adr;
  logic [DW-1:0]   lat_dwr;
  logic [DW/8-1:0] lat_sel;
  logic            lat_we;
  logic            lat_lock;

  // Address decode: walk downwards so the lowest matching index is left last.
  always_comb begin
    hit     = 1'b0;
    hit_idx = {IW{1'b0}};
    for (int i = NS - 1; i >= 0; i--) begin
      if ((host.m_adr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end else begin
        hit     = hit;
        hit_idx = hit_idx;
      end
    end
  end

  assign sel_ack   = dev.s_ack[idx];
  assign sel_err   = dev.s_err[idx];
  assign sel_stall = dev.s_stall[idx];
  assign sel_drd   = dev.s_drd[idx*DW +: DW];
  assign in_xfer   = (state == REQ) || (state == WAIT);
  assign cnt_inc   = cnt + 16'd1;
  // The count that this cycle completes; reaching TIMEOUT ends the wait.
  assign tmo       = (cnt_inc == TMO);
  // An abort (m_cyc low) suppresses any slave response in the same cycle.
  assign fwd       = in_xfer && host.m_cyc;

  // Next-state logic; a slave response is checked before the timeout so it wins.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (host.m_cyc && host.m_stb) begin
          accept    = 1'b1;
          state_nxt = hit ? REQ : RESP;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (!host.m_cyc) begin
          state_nxt = IDLE;
        end else if (sel_ack || sel_err) begin
          state_nxt = IDLE;
        end else if (tmo) begin
          state_nxt = RESP;
        end else if (!sel_stall) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = REQ;
        end
      end
      WAIT: begin
        if (!host.m_cyc) begin
          state_nxt = IDLE;
        end else if (sel_ack || sel_err) begin
          state_nxt = IDLE;
        end else if (tmo) begin
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= 16'd0;
      end else if (in_xfer) begin
        cnt <= cnt_inc;
      end else begin
        cnt <= cnt;
      end
    end
  end

  // Capture request fields and target index only for a mapped request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= {IW{1'b0}};
      lat_tag  <= {TW{1'b0}};
      lat_adr  <= {AW{1'b0}};
      lat_dwr  <= {DW{1'b0}};
      lat_sel  <= {(DW/8){1'b0}};
      lat_we   <= 1'b0;
      lat_lock <= 1'b0;
    end else if (accept && hit) begin
      idx      <= hit_idx;
      lat_tag  <= host.m_tag;
      lat_adr  <= host.m_adr;
      lat_dwr  <= host.m_dwr;
      lat_sel  <= host.m_sel;
      lat_we   <= host.m_we;
      lat_lock <= host.m_lock;
    end
  end

  assign dev.s_tag  = lat_tag;
  assign dev.s_adr  = lat_adr;
  assign dev.s_dwr  = lat_dwr;
  assign dev.s_sel  = lat_sel;
  assign dev.s_we   = lat_we;
  assign dev.s_lock = lat_lock;

  // Strobes decode straight from the state register so reset drops them at once.
  assign dev.s_cyc   = in_xfer ? (ONE << idx) : {NS{1'b0}};
  assign dev.s_stb   = (state == REQ) ? (ONE << idx) : {NS{1'b0}};
  assign host.m_stall = (state != IDLE);
  // ack together with err is reported as err only.
  assign host.m_ack  = fwd && sel_ack && !sel_err;
  assign host.m_err  = (state == RESP) || (fwd && sel_err);
  assign host.m_drd  = host.m_ack ? sel_drd : {DW{1'b0}};

endmodule

// File: tb/tb_wb_decoder_timeout.sv
// Directed bench for wb_decoder_timeout: decode, unmapped error, timeout,
// stall, ack/err priority, abort and mid-transaction reset.
module tb_wb_decoder_timeout;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TW = 3;
  localparam int NS = 4;
  // Slave 3 overlaps slaves 0..2 (bit 15 clear) to exercise lowest-index priority.
  localparam logic [NS*AW-1:0] BASE = {32'h0000_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'h0000_8000, 32'h0000_F000, 32'h0000_F000, 32'h0000_F000};

  logic clk = 1'b0;
  logic rst;
  int   n_cmp;
  int   n_mis;

  always #5 clk = ~clk;

  wb_decoder_timeout_if #(.DW(DW), .AW(AW), .TW(TW), .NS(NS)) bus ();

  wb_decoder_timeout #(
    .DW(DW), .AW(AW), .TW(TW), .NS(NS),
    .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .host (bus),
    .dev  (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle;
    bus.m_tag   = '0;
    bus.m_adr   = '0;
    bus.m_dwr   = '0;
    bus.m_sel   = '0;
    bus.m_stb   = 1'b0;
    bus.m_cyc   = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_lock  = 1'b0;
    bus.s_drd   = '0;
    bus.s_ack   = '0;
    bus.s_err   = '0;
    bus.s_stall = '0;
  endtask

  // Present a request in IDLE; it is accepted at the next rising edge.
  task automatic start(input logic [AW-1:0] a, input logic [TW-1:0] t);
    @(negedge clk);
    bus.m_cyc = 1'b1;
    bus.m_stb = 1'b1;
    bus.m_adr = a;
    bus.m_tag = t;
    bus.m_we  = 1'b0;
    bus.m_sel = 4'hF;
    #1;
    check_val("acc_stall", 64'(bus.m_stall), 64'd0);
  endtask

  task automatic next_cyc;
    @(negedge clk);
    bus.m_stb = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    bus_idle();
    rst = 1'b0;
    bus.m_cyc = 1'b1;
    bus.m_stb = 1'b1;
    bus.m_adr = 32'h0000_2004;
    #12;
    check_val("rst_stall", 64'(bus.m_stall), 64'd0);
    check_val("rst_cyc",   64'(bus.s_cyc),   64'd0);
    check_val("rst_stb",   64'(bus.s_stb),   64'd0);
    check_val("rst_ack",   64'(bus.m_ack),   64'd0);
    check_val("rst_err",   64'(bus.m_err),   64'd0);
    check_val("rst_adr",   64'(bus.s_adr),   64'd0);
    @(negedge clk);
    bus_idle();
    rst = 1'b1;

    // Read 0x2004 -> slave 2, ack three cycles after the strobe.
    start(32'h0000_2004, 3'd5);
    next_cyc; bus.s_stall = '0; #1;
    check_val("rd_stb",   64'(bus.s_stb),   64'h4);
    check_val("rd_cyc",   64'(bus.s_cyc),   64'h4);
    check_val("rd_stall", 64'(bus.m_stall), 64'd1);
    check_val("rd_sadr",  64'(bus.s_adr),   64'h2004);
    check_val("rd_stag",  64'(bus.s_tag),   64'd5);
    next_cyc; bus.s_ack = 4'b0010; bus.s_drd[1*DW +: DW] = 32'hDEAD; #1;
    check_val("rd_stb_w", 64'(bus.s_stb),   64'd0);
    check_val("rd_cyc_w", 64'(bus.s_cyc),   64'h4);
    check_val("stray_ack", 64'(bus.m_ack),  64'd0);
    check_val("stray_drd", 64'(bus.m_drd),  64'd0);
    next_cyc; bus.s_ack = '0; #1;
    check_val("rd_wait_ack", 64'(bus.m_ack), 64'd0);
    next_cyc; bus.s_ack = 4'b0100; bus.s_drd[2*DW +: DW] = 32'h0000_CAFE; #1;
    check_val("rd_ack", 64'(bus.m_ack), 64'd1);
    check_val("rd_drd", 64'(bus.m_drd), 64'hCAFE);
    check_val("rd_err", 64'(bus.m_err), 64'd0);
    next_cyc; bus.s_ack = '0; bus.m_cyc = 1'b0; #1;
    check_val("rd_done_ack", 64'(bus.m_ack),   64'd0);
    check_val("rd_done_drd", 64'(bus.m_drd),   64'd0);
    check_val("rd_done_stl", 64'(bus.m_stall), 64'd0);
    check_val("rd_done_cyc", 64'(bus.s_cyc),   64'd0);

    // Unmapped 0x9000 -> one-cycle m_err, no slave strobed.
    start(32'h0000_9000, 3'd0);
    next_cyc; #1;
    check_val("um_err",   64'(bus.m_err),   64'd1);
    check_val("um_cyc",   64'(bus.s_cyc),   64'd0);
    check_val("um_stb",   64'(bus.s_stb),   64'd0);
    check_val("um_stall", 64'(bus.m_stall), 64'd1);
    check_val("um_ack",   64'(bus.m_ack),   64'd0);
    next_cyc; bus.m_cyc = 1'b0; #1;
    check_val("um_err_end", 64'(bus.m_err),   64'd0);
    check_val("um_stl_end", 64'(bus.m_stall), 64'd0);

    // Timeout of 8 on slave 1: m_err in the 9th cycle after accept.
    start(32'h0000_1010, 3'd1);
    for (int k = 1; k <= 8; k++) begin
      next_cyc; #1;
      check_val("to_cyc", 64'(bus.s_cyc), 64'h2);
      check_val("to_err", 64'(bus.m_err), 64'd0);
    end
    next_cyc; #1;
    check_val("to_err9", 64'(bus.m_err), 64'd1);
    check_val("to_cyc9", 64'(bus.s_cyc), 64'd0);
    check_val("to_stb9", 64'(bus.s_stb), 64'd0);
    next_cyc; bus.m_cyc = 1'b0; #1;
    check_val("to_err10", 64'(bus.m_err),   64'd0);
    check_val("to_stl10", 64'(bus.m_stall), 64'd0);

    // Slave 3 stalls 5 cycles; its ack lands on the timeout cycle and wins.
    start(32'h0000_5000, 3'd2);
    for (int k = 1; k <= 5; k++) begin
      next_cyc; bus.s_stall = 4'b1000; #1;
      check_val("st_stb",   64'(bus.s_stb),   64'h8);
      check_val("st_stall", 64'(bus.m_stall), 64'd1);
    end
    next_cyc; bus.s_stall = '0; #1;
    check_val("st_stb6", 64'(bus.s_stb), 64'h8);
    next_cyc; #1;
    check_val("st_stb7",   64'(bus.s_stb),   64'd0);
    check_val("st_cyc7",   64'(bus.s_cyc),   64'h8);
    check_val("st_stall7", 64'(bus.m_stall), 64'd1);
    next_cyc; bus.s_ack = 4'b1000; bus.s_drd[3*DW +: DW] = 32'h0000_1234; #1;
    check_val("tie_ack", 64'(bus.m_ack), 64'd1);
    check_val("tie_drd", 64'(bus.m_drd), 64'h1234);
    check_val("tie_err", 64'(bus.m_err), 64'd0);
    next_cyc; bus.s_ack = '0; bus.m_cyc = 1'b0; #1;
    check_val("tie_err9", 64'(bus.m_err),   64'd0);
    check_val("tie_stl9", 64'(bus.m_stall), 64'd0);

    // 0x0100 matches slaves 0 and 3; slave 0 wins. ack+err -> err only.
    start(32'h0000_0100, 3'd3);
    next_cyc; #1;
    check_val("pri_cyc", 64'(bus.s_cyc), 64'h1);
    next_cyc; bus.s_ack = 4'b0001; bus.s_err = 4'b0001; bus.s_drd[0 +: DW] = 32'h0000_FFFF; #1;
    check_val("ae_err", 64'(bus.m_err), 64'd1);
    check_val("ae_ack", 64'(bus.m_ack), 64'd0);
    check_val("ae_drd", 64'(bus.m_drd), 64'd0);
    next_cyc; bus.s_ack = '0; bus.s_err = '0; bus.m_cyc = 1'b0; #1;
    check_val("ae_err_end", 64'(bus.m_err),   64'd0);
    check_val("ae_stl_end", 64'(bus.m_stall), 64'd0);

    // Abort in WAIT, late ack ignored, next request accepted.
    start(32'h0000_1000, 3'd4);
    next_cyc; #1;
    check_val("ab_cyc", 64'(bus.s_cyc), 64'h2);
    next_cyc; bus.m_cyc = 1'b0; #1;
    check_val("ab_ack", 64'(bus.m_ack), 64'd0);
    check_val("ab_err", 64'(bus.m_err), 64'd0);
    next_cyc; bus.s_ack = 4'b0010; bus.m_cyc = 1'b1; bus.m_stb = 1'b1; bus.m_adr = 32'h0000_2000; #1;
    check_val("ab_late_ack", 64'(bus.m_ack),   64'd0);
    check_val("ab_late_cyc", 64'(bus.s_cyc),   64'd0);
    check_val("ab_late_stl", 64'(bus.m_stall), 64'd0);
    next_cyc; bus.s_ack = '0; #1;
    check_val("ab_new_stb", 64'(bus.s_stb), 64'h4);
    check_val("ab_new_adr", 64'(bus.s_adr), 64'h2000);
    next_cyc; bus.s_ack = 4'b0100; #1;
    check_val("ab_new_ack", 64'(bus.m_ack), 64'd1);
    check_val("ab_new_drd", 64'(bus.m_drd), 64'hCAFE);
    next_cyc; bus.s_ack = '0; bus.m_cyc = 1'b0; #1;
    check_val("ab_new_end", 64'(bus.m_stall), 64'd0);

    // Reset asserted while in REQ.
    start(32'h0000_2008, 3'd6);
    next_cyc; #1;
    check_val("mr_stb", 64'(bus.s_stb), 64'h4);
    #1 rst = 1'b0;
    #1;
    check_val("mr_cyc",   64'(bus.s_cyc),   64'd0);
    check_val("mr_stb0",  64'(bus.s_stb),   64'd0);
    check_val("mr_stall", 64'(bus.m_stall), 64'd0);
    check_val("mr_ack",   64'(bus.m_ack),   64'd0);
    check_val("mr_err",   64'(bus.m_err),   64'd0);
    check_val("mr_adr",   64'(bus.s_adr),   64'd0);
    check_val("mr_tag",   64'(bus.s_tag),   64'd0);
    next_cyc; rst = 1'b1; bus_idle(); #1;
    check_val("mr_post_stl", 64'(bus.m_stall), 64'd0);
    check_val("mr_post_cyc", 64'(bus.s_cyc),   64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/wb_decoder_timeout.md
WB_DECODER_TIMEOUT -- requirements
Module: wb_decoder_timeout

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter TW, default 3, tag width.
REQ-004 SHALL have parameter NS, default 4, slave port count (1..8).
REQ-005 SHALL have parameter SLV_BASE, default {NS{AW'0}}, packed NS*AW per-slave base addresses.
REQ-006 SHALL have parameter SLV_MASK, default {NS{AW'0}}, packed NS*AW per-slave address masks.
REQ-007 SHALL have parameter TIMEOUT, default 255, cycles without slave response before error (1..65535).
REQ-008 clk  in  1  single clock, all logic on rising edge.
REQ-009 rst  in  1  asynchronous reset, active-low.
REQ-010 m_tag, m_adr, m_dwr, m_sel  in  TW, AW, DW, DW/8  master request fields.
REQ-011 m_stb, m_cyc, m_we, m_lock  in  1 each  master controls.
REQ-012 m_drd  out  DW  read data to master.
REQ-013 m_ack, m_err, m_stall  out  1 each  master response and flow control.
REQ-014 s_tag, s_adr, s_dwr, s_sel, s_we, s_lock  out  shared  registered copy of master fields, broadcast to all slaves.
REQ-015 s_cyc, s_stb  out  NS  per-slave strobes.
REQ-016 s_drd  in  NS*DW  per-slave read data.
REQ-017 s_ack, s_err, s_stall  in  NS each  per-slave responses.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, RESP.
REQ-019 Slave i SHALL match when (m_adr & SLV_MASK[i]) == SLV_BASE[i]; the lowest matching index SHALL win.
REQ-020 In IDLE, m_stall SHALL be 0; in every other state m_stall SHALL be 1 (one outstanding transaction).
REQ-021 IDLE with m_cyc&m_stb and a match SHALL register request fields and the index, then go to REQ.
REQ-022 IDLE with m_cyc&m_stb and no match SHALL go to RESP with m_err=1 for exactly one cycle; no slave is strobed.
REQ-023 In REQ, s_cyc[idx] and s_stb[idx] SHALL be 1; the FSM SHALL move to WAIT on the first cycle s_stall[idx]==0.
REQ-024 In WAIT, s_cyc[idx]=1 and s_stb[idx]=0; the FSM SHALL go to IDLE on s_ack[idx] or s_err[idx].
REQ-025 Slave ack/err SHALL be forwarded combinationally in that cycle: m_ack=s_ack[idx], m_err=s_err[idx], m_drd=s_drd[idx].
REQ-026 A 16-bit timeout counter SHALL clear on leaving IDLE and increment each cycle in REQ/WAIT.
REQ-027 When the count equals TIMEOUT, the FSM SHALL drop s_cyc/s_stb and go to RESP, issuing a single-cycle m_err.
REQ-028 If slave ack/err and timeout coincide, the slave response SHALL win; no m_err from timeout.
REQ-029 A slave ack and err asserted in the same cycle SHALL be forwarded as m_err only.
REQ-030 If m_cyc drops in REQ/WAIT, the FSM SHALL abort to IDLE next cycle, drop s_cyc, and not pulse m_ack/m_err.
REQ-031 Slave responses arriving at ports other than idx, or while in IDLE, SHALL be ignored.
REQ-032 m_drd SHALL be 0 whenever m_ack is 0.
REQ-033 RESP SHALL last one cycle, then return to IDLE.

Reset
REQ-034 On rst low, asynchronously: FSM=IDLE, counter=0, s_cyc=s_stb=0, m_ack=m_err=0, m_stall=0, registered fields=0.
REQ-035 Reset asserted mid-transaction SHALL drop all slave strobes immediately, with no response to the master.

Verification
REQ-036 NS=4, SLV_BASE[2]=0x2000, mask 0xF000; read 0x2004, slave 2 acks 3 cycles later with 0xCAFE -> s_stb[2] high 1 cycle, m_ack for 1 cycle, m_drd=0xCAFE.
REQ-037 Access to unmapped 0x9000 -> m_err 1 cycle later, s_cyc all 0.
REQ-038 TIMEOUT=8, slave never responds -> m_err on the 9th cycle after accept, s_cyc[idx] dropped.
REQ-039 Slave holds s_stall 5 cycles -> s_stb stays high 6 cycles, then drops; m_stall stays high until ack.
REQ-040 m_cyc dropped in WAIT, later s_ack -> no m_ack; the FSM is IDLE and accepts the next request.
REQ-041 rst low during REQ -> s_cyc/s_stb 0 in the same cycle; all outputs at reset values.
